pht_gshare_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 18 +
 rtl/pht_counter_next.sv | 22 ++
 rtl/pht_gshare_predictor.sv | 124 ++++++++++++
 tb/tb_pht_gshare_predictor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: counter encodings and default table geometry.
package bp_pkg;

   typedef logic [1:0] ctr_t;

   // 2-bit saturating counter encodings; MSB is the predicted direction
   localparam ctr_t SNT = 2'b00;
   localparam ctr_t WNT = 2'b01;
   localparam ctr_t WT  = 2'b10;
   localparam ctr_t ST  = 2'b11;

   // Counters come out of reset strongly taken
   localparam ctr_t CNT_RESET = ST;

   localparam int unsigned BP_INDEX_W = 8;
   localparam int unsigned BP_GHR_W   = 8;

endpackage : bp_pkg

// File: rtl/pht_counter_next.sv
// Next-state function of a 2-bit saturating direction counter.
module pht_counter_next
   import bp_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       taken_i,
   output logic [1:0] state_o
);

   // Move one step toward the resolved direction, saturating at the ends
   always_comb begin
      state_o = state_i;
      case (state_i)
         ST:      state_o = taken_i ? ST : WT;
         WT:      state_o = taken_i ? ST : WNT;
         WNT:     state_o = taken_i ? WT : SNT;
         SNT:     state_o = taken_i ? WNT : SNT;
         default: state_o = state_i;
      endcase
   end

endmodule : pht_counter_next

// File: rtl/pht_gshare_predictor.sv
// Gshare pattern history table: 1-cycle lookup, backend counter updates,
// speculative global history with checkpoint recovery on mispredict.
module pht_gshare_predictor
   import bp_pkg::*;
#(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INDEX_W = BP_INDEX_W,
   parameter int unsigned GHR_W   = BP_GHR_W
) (
   input  logic               clk,
   input  logic               resetn,

   input  logic               lk_valid_i,
   input  logic [PC_W-1:0]    lk_pc_i,

   output logic               pred_valid_o,
   output logic               pred_taken_o,
   output logic [INDEX_W-1:0] pred_index_o,
   output logic [GHR_W-1:0]   pred_ghr_o,

   input  logic               upd_valid_i,
   input  logic [INDEX_W-1:0] upd_index_i,
   input  logic               upd_taken_i,
   input  logic               upd_mispredict_i,
   input  logic [GHR_W-1:0]   upd_ghr_i
);

   localparam int unsigned DEPTH = 1 << INDEX_W;

   ctr_t               cnt_q [DEPTH];
   logic [GHR_W-1:0]   ghr_q, ghr_d;

   logic               pred_valid_q, pred_valid_d;
   logic               pred_taken_q, pred_taken_d;
   logic [INDEX_W-1:0] pred_index_q, pred_index_d;
   logic [GHR_W-1:0]   pred_ghr_q,   pred_ghr_d;

   logic [INDEX_W-1:0] lk_idx_c;
   ctr_t               upd_cur_c;
   ctr_t               upd_next_c;
   ctr_t               lk_cnt_c;
   logic               recover_c;
   logic               lk_fire_c;
   logic               bypass_c;

   // PC bits outside the index field and the checkpoint MSB never reach the table
   logic               unused_bits_c;
   assign unused_bits_c = ^{lk_pc_i[PC_W-1:INDEX_W+2], lk_pc_i[1:0], upd_ghr_i[GHR_W-1]};

   // Gshare index: word-aligned PC bits folded with the speculative history
   assign lk_idx_c = lk_pc_i[INDEX_W+1:2] ^ INDEX_W'(ghr_q);

   // Update path read-modify-write
   assign upd_cur_c = cnt_q[upd_index_i];

   pht_counter_next u_counter_next (
      .state_i (upd_cur_c),
      .taken_i (upd_taken_i),
      .state_o (upd_next_c)
   );

   // Mispredict recovery squashes any lookup in the same cycle
   assign recover_c = upd_valid_i & upd_mispredict_i;
   assign lk_fire_c = lk_valid_i & ~recover_c;

   // Write-first: a same-cycle update to the looked-up entry is visible to the lookup
   assign bypass_c = upd_valid_i && (upd_index_i == lk_idx_c);
   assign lk_cnt_c = bypass_c ? upd_next_c : cnt_q[lk_idx_c];

   // Next history and prediction register contents
   always_comb begin
      ghr_d        = ghr_q;
      pred_valid_d = lk_fire_c;
      pred_taken_d = pred_taken_q;
      pred_index_d = pred_index_q;
      pred_ghr_d   = pred_ghr_q;

      if (lk_fire_c) begin
         pred_taken_d = lk_cnt_c[1];
         pred_index_d = lk_idx_c;
         pred_ghr_d   = ghr_q;
      end

      if (recover_c) begin
         ghr_d = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
      end else if (lk_fire_c) begin
         ghr_d = {ghr_q[GHR_W-2:0], lk_cnt_c[1]};
      end
   end

   // Counter table; an update coinciding with reset is discarded
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= CNT_RESET;
         end
      end else if (upd_valid_i) begin
         cnt_q[upd_index_i] <= upd_next_c;
      end
   end

   // History and prediction output registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_index_q <= '0;
         pred_ghr_q   <= '0;
      end else begin
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_index_q <= pred_index_d;
         pred_ghr_q   <= pred_ghr_d;
      end
   end

   assign pred_valid_o = pred_valid_q;
   assign pred_taken_o = pred_taken_q;
   assign pred_index_o = pred_index_q;
   assign pred_ghr_o   = pred_ghr_q;

endmodule : pht_gshare_predictor

// File: tb/tb_pht_gshare_predictor.sv
// Directed plus randomized bench for pht_gshare_predictor against an integer reference model.
module tb_pht_gshare_predictor;

   localparam int unsigned PC_W    = 32;
   localparam int unsigned INDEX_W = 8;
   localparam int unsigned GHR_W   = 8;
   localparam int unsigned DEPTH   = 1 << INDEX_W;

   logic               clk;
   logic               resetn;
   logic               lk_valid_i;
   logic [PC_W-1:0]    lk_pc_i;
   logic               pred_valid_o;
   logic               pred_taken_o;
   logic [INDEX_W-1:0] pred_index_o;
   logic [GHR_W-1:0]   pred_ghr_o;
   logic               upd_valid_i;
   logic [INDEX_W-1:0] upd_index_i;
   logic               upd_taken_i;
   logic               upd_mispredict_i;
   logic [GHR_W-1:0]   upd_ghr_i;

   int n_tests;
   int n_fail;

   // Reference model: counters as integers 0..3, history as an integer
   int m_cnt [DEPTH];
   int m_ghr;

   pht_gshare_predictor #(
      .PC_W    (PC_W),
      .INDEX_W (INDEX_W),
      .GHR_W   (GHR_W)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .lk_valid_i       (lk_valid_i),
      .lk_pc_i          (lk_pc_i),
      .pred_valid_o     (pred_valid_o),
      .pred_taken_o     (pred_taken_o),
      .pred_index_o     (pred_index_o),
      .pred_ghr_o       (pred_ghr_o),
      .upd_valid_i      (upd_valid_i),
      .upd_index_i      (upd_index_i),
      .upd_taken_i      (upd_taken_i),
      .upd_mispredict_i (upd_mispredict_i),
      .upd_ghr_i        (upd_ghr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [PC_W-1:0] pc_for(input int idx);
      return PC_W'(((idx ^ m_ghr) & (DEPTH - 1)) << 2);
   endfunction

   // One cycle: drive inputs, advance the model, then compare registered outputs
   task automatic step(input bit lk, input logic [PC_W-1:0] pc, input bit uv,
                       input int ui, input bit ut, input bit um, input int ug);
      int  idx;
      int  ghr_before;
      bit  exp_valid;
      bit  exp_taken;
      @(negedge clk);
      lk_valid_i       = lk;
      lk_pc_i          = pc;
      upd_valid_i      = uv;
      upd_index_i      = INDEX_W'(ui);
      upd_taken_i      = ut;
      upd_mispredict_i = um;
      upd_ghr_i        = GHR_W'(ug);

      ghr_before = m_ghr;
      idx = ((pc >> 2) ^ m_ghr) & (DEPTH - 1);
      if (uv) begin
         if (ut) m_cnt[ui] = (m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1;
         else    m_cnt[ui] = (m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1;
      end
      exp_valid = lk && !(uv && um);
      exp_taken = (m_cnt[idx] >= 2);
      if (uv && um)     m_ghr = ((ug << 1) | int'(ut)) % DEPTH % (1 << GHR_W);
      else if (exp_valid) m_ghr = ((m_ghr << 1) | int'(exp_taken)) % (1 << GHR_W);

      @(posedge clk);
      #1;
      check("pred_valid", pred_valid_o, exp_valid);
      if (exp_valid) begin
         check("pred_taken", pred_taken_o, exp_taken);
         check("pred_index", pred_index_o, idx);
         check("pred_ghr",   pred_ghr_o,   ghr_before);
      end
   endtask

   // Reset cycle with a live lookup and update on the inputs
   task automatic do_reset();
      @(negedge clk);
      resetn           = 1'b0;
      lk_valid_i       = 1'b1;
      lk_pc_i          = PC_W'($urandom);
      upd_valid_i      = 1'b1;
      upd_index_i      = INDEX_W'($urandom);
      upd_taken_i      = 1'b0;
      upd_mispredict_i = 1'b1;
      upd_ghr_i        = GHR_W'($urandom);
      for (int i = 0; i < DEPTH; i++) m_cnt[i] = 3;
      m_ghr = 0;
      @(posedge clk);
      #1;
      check("rst_valid", pred_valid_o, 0);
      check("rst_taken", pred_taken_o, 0);
      check("rst_index", pred_index_o, 0);
      check("rst_ghr",   pred_ghr_o,   0);
      @(negedge clk);
      resetn           = 1'b1;
      lk_valid_i       = 1'b0;
      upd_valid_i      = 1'b0;
      upd_mispredict_i = 1'b0;
   endtask

   initial begin
      n_tests          = 0;
      n_fail           = 0;
      resetn           = 1'b0;
      lk_valid_i       = 1'b0;
      lk_pc_i          = '0;
      upd_valid_i      = 1'b0;
      upd_index_i      = '0;
      upd_taken_i      = 1'b0;
      upd_mispredict_i = 1'b0;
      upd_ghr_i        = '0;

      do_reset();

      // First lookup after reset
      step(1, 32'h0000_0010, 0, 0, 0, 0, 0);
      check("first_taken", pred_taken_o, 1);
      check("first_index", pred_index_o, 8'h04);
      check("first_ghr",   pred_ghr_o,   8'h00);
      step(1, pc_for(0), 0, 0, 0, 0, 0);
      check("first_ghr_shift", pred_ghr_o, 8'h01);

      // Walk counter[4] down to 00, then back up
      for (int k = 0; k < 3; k++) step(0, '0, 1, 4, 0, 0, 0);
      step(1, pc_for(4), 0, 0, 0, 0, 0);
      check("walk_down", pred_taken_o, 0);
      step(0, '0, 1, 4, 1, 0, 0);
      step(1, pc_for(4), 0, 0, 0, 0, 0);
      check("walk_wnt", pred_taken_o, 0);
      step(0, '0, 1, 4, 1, 0, 0);
      step(1, pc_for(4), 0, 0, 0, 0, 0);
      check("walk_wt", pred_taken_o, 1);

      // Saturate high at 4, low at 5
      for (int k = 0; k < 3; k++) step(0, '0, 1, 4, 1, 0, 0);
      step(1, pc_for(4), 0, 0, 0, 0, 0);
      check("sat_high", pred_taken_o, 1);
      for (int k = 0; k < 4; k++) step(0, '0, 1, 5, 0, 0, 0);
      step(1, pc_for(5), 0, 0, 0, 0, 0);
      check("sat_low", pred_taken_o, 0);

      // Bypass: counter[4] = 10, same-cycle not-taken update must be seen
      step(0, '0, 1, 4, 0, 0, 0);
      step(1, pc_for(4), 1, 4, 0, 0, 0);
      check("bypass_taken", pred_taken_o, 0);
      check("bypass_index", pred_index_o, 8'h04);

      // Recovery: force GHR to 0x5A, then recover to 0x27 with a squashed lookup
      step(0, '0, 1, 9, 0, 1, 8'h2D);
      step(1, pc_for(0), 0, 0, 0, 0, 0);
      check("ghr_5a", pred_ghr_o, 8'h5A);
      step(0, '0, 1, 9, 0, 1, 8'h2D);
      step(1, pc_for(3), 1, 9, 1, 1, 8'h13);
      step(1, pc_for(3), 0, 0, 0, 0, 0);
      check("ghr_27", pred_ghr_o, 8'h27);

      // Correct-prediction update leaves history alone
      step(0, '0, 1, 7, 1, 0, 8'hFF);
      step(1, pc_for(7), 0, 0, 0, 0, 0);

      // Reset mid-operation restores counters and history
      do_reset();
      step(1, pc_for(5), 0, 0, 0, 0, 0);
      check("post_rst_taken5", pred_taken_o, 1);
      check("post_rst_ghr",    pred_ghr_o,   0);
      step(1, pc_for(4), 0, 0, 0, 0, 0);
      check("post_rst_taken4", pred_taken_o, 1);

      // Randomized traffic; indices biased to a small set to provoke aliasing and bypass
      for (int n = 0; n < 3000; n++) begin
         int ui;
         ui = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                          : int'($urandom_range(0, 7));
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) == 0) ? pc_for($urandom_range(0, 7)) : PC_W'($urandom),
              $urandom_range(0, 2) != 0,
              ui,
              $urandom_range(0, 1),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, DEPTH - 1));
      end

      step(0, '0, 0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pht_gshare_predictor
